// File: rtl/gold_miner_pkg.sv
// Shared types and helpers for the gold miner hook and object blocks.
// Direction vectors point outward from the pivot; object blocks negate them to pull back.
package gold_miner_pkg;

  typedef enum logic [2:0] {
    HOOK_SWING          = 3'd0,
    HOOK_EXTEND         = 3'd1,
    HOOK_RETRACT        = 3'd2,
    HOOK_RETRACT_LOADED = 3'd3
  } hook_state_t;

  typedef struct packed {
    logic signed [3:0] dx;
    logic signed [3:0] dy;
  } hook_dir_t;

  localparam logic signed [11:0] SCREEN_W    = 12'sd640;
  localparam logic signed [11:0] SCREEN_H    = 12'sd480;
  localparam logic [3:0]         R_MODE_MAX  = 4'd10;
  localparam logic [3:0]         R_MODE_DOWN = 4'd5;

  function automatic hook_dir_t dir_of(input logic [3:0] r_mode);
    hook_dir_t d;
    case (r_mode)
      4'd0:    d = '{dx:  4'sd6, dy: 4'sd0};
      4'd1:    d = '{dx:  4'sd6, dy: 4'sd1};
      4'd2:    d = '{dx:  4'sd5, dy: 4'sd2};
      4'd3:    d = '{dx:  4'sd4, dy: 4'sd3};
      4'd4:    d = '{dx:  4'sd2, dy: 4'sd4};
      4'd6:    d = '{dx: -4'sd2, dy: 4'sd4};
      4'd7:    d = '{dx: -4'sd4, dy: 4'sd3};
      4'd8:    d = '{dx: -4'sd5, dy: 4'sd2};
      4'd9:    d = '{dx: -4'sd6, dy: 4'sd1};
      4'd10:   d = '{dx: -4'sd6, dy: 4'sd0};
      default: d = '{dx:  4'sd0, dy: 4'sd6};
    endcase
    return d;
  endfunction

  // pivot + n*d in 12-bit signed; callers truncate to 10 bits for the pixel bus
  function automatic logic signed [11:0] tail_coord(input logic [9:0] pivot,
                                                    input logic [10:0] n,
                                                    input logic signed [3:0] d);
    logic signed [11:0] p_s;
    logic signed [11:0] n_s;
    logic signed [11:0] d_s;
    p_s = $signed({2'b00, pivot});
    n_s = $signed({1'b0, n});
    d_s = {{8{d[3]}}, d};
    return p_s + n_s * d_s;
  endfunction

endpackage

// File: rtl/hook_tick_div.sv
// Free-running step divider: counts 0..div_i-1 and pulses tick_o on the last count.
// clr_i restarts the count so every hook state begins a full step period.
module hook_tick_div (
  input  logic        Clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic [31:0] div_i,
  output logic        tick_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign tick_o = (cnt_q == (div_i - 32'd1));

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hook_controller.sv
// Per-player hook controller: swings the angle, extends and retracts the rope,
// and publishes the registered hook-tail position for the object blocks.
//
// state               | meaning
// HOOK_SWING          | angle ping-pongs 0..10, waiting for a fire edge
// HOOK_EXTEND         | rope grows one step per tick until edge/limit or catch
// HOOK_RETRACT        | empty hook returns one step per tick
// HOOK_RETRACT_LOADED | hook returns slowly with a caught object
module hook_controller
  import gold_miner_pkg::*;
#(
  parameter logic [9:0]  PIVOT_X            = 10'd320,
  parameter logic [9:0]  PIVOT_Y            = 10'd40,
  parameter logic [31:0] SWING_DIV          = 32'd4000000,
  parameter logic [31:0] EXTEND_DIV         = 32'd500000,
  parameter logic [31:0] RETRACT_DIV        = 32'd500000,
  parameter logic [31:0] RETRACT_DIV_LOADED = 32'd8000000,
  parameter logic [9:0]  MAX_STEPS          = 10'd60
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       is_new_game_start,
  input  logic       fire,
  input  logic       is_catch,
  output logic [3:0] R_mode,
  output logic [2:0] state_out,
  output logic [9:0] tailx,
  output logic [9:0] taily,
  output logic [9:0] hook_len
);

  hook_state_t state_q, state_d;
  logic [3:0]  r_mode_q, r_mode_d;
  logic        dir_up_q, dir_up_d;
  logic [9:0]  len_q, len_d;
  logic        fire_q;
  logic [9:0]  tailx_q, taily_q;

  logic               rst;
  logic               fire_rise;
  logic               tick;
  logic               div_clr;
  logic [31:0]        div_sel;
  hook_dir_t          dir;
  logic [10:0]        len_nxt;
  logic signed [11:0] x_nxt, y_nxt;
  logic               step_ok;
  logic               swing_up;

  assign rst       = reset | is_new_game_start;
  assign fire_rise = fire & ~fire_q;
  assign dir       = dir_of(r_mode_q);
  assign len_nxt   = {1'b0, len_q} + 11'd1;
  assign x_nxt     = tail_coord(PIVOT_X, len_nxt, dir.dx);
  assign y_nxt     = tail_coord(PIVOT_Y, len_nxt, dir.dy);
  assign step_ok   = (x_nxt >= 12'sd0) && (x_nxt < SCREEN_W) &&
                     (y_nxt >= 12'sd0) && (y_nxt < SCREEN_H) &&
                     (len_nxt <= {1'b0, MAX_STEPS});

  always_comb begin
    case (state_q)
      HOOK_EXTEND:         div_sel = EXTEND_DIV;
      HOOK_RETRACT:        div_sel = RETRACT_DIV;
      HOOK_RETRACT_LOADED: div_sel = RETRACT_DIV_LOADED;
      default:             div_sel = SWING_DIV;
    endcase
  end

  assign div_clr = (state_d != state_q);

  hook_tick_div u_div (
    .Clk    (Clk),
    .reset  (rst),
    .clr_i  (div_clr),
    .div_i  (div_sel),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    r_mode_d = r_mode_q;
    dir_up_d = dir_up_q;
    len_d    = len_q;
    swing_up = (dir_up_q && (r_mode_q != R_MODE_MAX)) || (r_mode_q == 4'd0);

    case (state_q)
      HOOK_SWING: begin
        if (fire_rise) begin
          state_d = HOOK_EXTEND;
          len_d   = '0;
        end else if (tick) begin
          // the flag flips on arrival at an end so the end value is shown once
          if (swing_up) begin
            r_mode_d = r_mode_q + 4'd1;
            dir_up_d = (r_mode_q + 4'd1) != R_MODE_MAX;
          end else begin
            r_mode_d = r_mode_q - 4'd1;
            dir_up_d = (r_mode_q == 4'd1);
          end
        end
      end
      HOOK_EXTEND: begin
        if (is_catch) begin
          state_d = HOOK_RETRACT_LOADED;
        end else if (tick) begin
          if (step_ok) begin
            len_d = len_nxt[9:0];
          end else begin
            state_d = HOOK_RETRACT;
          end
        end
      end
      HOOK_RETRACT: begin
        if (len_q == 10'd0) begin
          state_d = HOOK_SWING;
        end else if (is_catch) begin
          state_d = HOOK_RETRACT_LOADED;
        end else if (tick) begin
          len_d = len_q - 10'd1;
        end
      end
      HOOK_RETRACT_LOADED: begin
        if (len_q == 10'd0) begin
          state_d = HOOK_SWING;
        end else if (tick) begin
          len_d = len_q - 10'd1;
        end
      end
      default: begin
        state_d = HOOK_SWING;
        len_d   = '0;
      end
    endcase

    if (r_mode_q > R_MODE_MAX) begin
      r_mode_d = R_MODE_DOWN;
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q  <= HOOK_SWING;
      r_mode_q <= R_MODE_DOWN;
      dir_up_q <= 1'b1;
      len_q    <= '0;
      fire_q   <= 1'b0;
      tailx_q  <= PIVOT_X;
      taily_q  <= PIVOT_Y;
    end else begin
      state_q  <= state_d;
      r_mode_q <= r_mode_d;
      dir_up_q <= dir_up_d;
      len_q    <= len_d;
      fire_q   <= fire;
      tailx_q  <= 10'(tail_coord(PIVOT_X, {1'b0, len_q}, dir.dx));
      taily_q  <= 10'(tail_coord(PIVOT_Y, {1'b0, len_q}, dir.dy));
    end
  end

  assign R_mode    = r_mode_q;
  assign state_out = state_q;
  assign tailx     = tailx_q;
  assign taily     = taily_q;
  assign hook_len  = len_q;

endmodule

// File: tb/tb_hook_controller.sv
// Bench for hook_controller: two instances (rope limit 8 and 60) share stimulus;
// a reference model queues expected outputs, a monitor pops and compares each cycle.
module tb_hook_controller;

  logic       Clk;
  logic       rst_in, ng_in, fire_in, catch_in;
  logic [3:0] r0, r1;
  logic [2:0] state0, state1;
  logic [9:0] tx0, ty0, len0, tx1, ty1, len1;

  int checks   = 0;
  int failures = 0;
  int popped   = 0;

  typedef struct {
    int st;
    int n;
    int r;
    int tx;
    int ty;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int DX [0:10] = '{6, 6, 5, 4, 2, 0, -2, -4, -5, -6, -6};
  int DY [0:10] = '{0, 1, 2, 3, 4, 6, 4, 3, 2, 1, 0};
  int SWING_EXP [0:9] = '{6, 7, 8, 9, 10, 9, 8, 7, 6, 5};

  // model state: st, rope length, position p in the 20-step ping-pong cycle,
  // cycles since the last step or state entry, previous fire, registered tail
  int m_st [2];
  int m_n  [2];
  int m_p  [2];
  int m_ph [2];
  int m_fq [2];
  int m_tx [2];
  int m_ty [2];

  hook_controller #(
    .PIVOT_X(10'd320), .PIVOT_Y(10'd40), .SWING_DIV(32'd4), .EXTEND_DIV(32'd2),
    .RETRACT_DIV(32'd2), .RETRACT_DIV_LOADED(32'd6), .MAX_STEPS(10'd8)
  ) u_dut0 (
    .Clk(Clk), .reset(rst_in), .is_new_game_start(ng_in), .fire(fire_in),
    .is_catch(catch_in), .R_mode(r0), .state_out(state0), .tailx(tx0),
    .taily(ty0), .hook_len(len0)
  );

  hook_controller #(
    .PIVOT_X(10'd320), .PIVOT_Y(10'd40), .SWING_DIV(32'd4), .EXTEND_DIV(32'd2),
    .RETRACT_DIV(32'd2), .RETRACT_DIV_LOADED(32'd6), .MAX_STEPS(10'd60)
  ) u_dut1 (
    .Clk(Clk), .reset(rst_in), .is_new_game_start(ng_in), .fire(fire_in),
    .is_catch(catch_in), .R_mode(r1), .state_out(state1), .tailx(tx1),
    .taily(ty1), .hook_len(len1)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic int rmode(input int p);
    return (p <= 10) ? p : 20 - p;
  endfunction

  task automatic model_step(input int i, input int maxn);
    int   st, n, r, nst, nn, div, nx, ny;
    bit   tick, ok;
    exp_t e;
    if (rst_in || ng_in) begin
      m_st[i] = 0; m_n[i] = 0; m_p[i] = 5; m_ph[i] = 0; m_fq[i] = 0;
      m_tx[i] = 320; m_ty[i] = 40;
    end else begin
      st = m_st[i];
      n  = m_n[i];
      r  = rmode(m_p[i]);
      m_tx[i] = (320 + n * DX[r]) & 1023;
      m_ty[i] = (40 + n * DY[r]) & 1023;
      div  = (st == 0) ? 4 : (st == 3) ? 6 : 2;
      tick = (m_ph[i] == div - 1);
      nx   = 320 + (n + 1) * DX[r];
      ny   = 40 + (n + 1) * DY[r];
      ok   = (nx >= 0) && (nx < 640) && (ny >= 0) && (ny < 480) && (n + 1 <= maxn);
      nst  = st;
      nn   = n;
      case (st)
        0: begin
          if (fire_in && m_fq[i] == 0) begin nst = 1; nn = 0; end
          else if (tick) m_p[i] = (m_p[i] + 1) % 20;
        end
        1: begin
          if (catch_in) nst = 3;
          else if (tick) begin
            if (ok) nn = n + 1;
            else nst = 2;
          end
        end
        2: begin
          if (n == 0) nst = 0;
          else if (catch_in) nst = 3;
          else if (tick) nn = n - 1;
        end
        default: begin
          if (n == 0) nst = 0;
          else if (tick) nn = n - 1;
        end
      endcase
      m_ph[i] = (nst != st || tick) ? 0 : m_ph[i] + 1;
      m_st[i] = nst;
      m_n[i]  = nn;
      m_fq[i] = fire_in ? 1 : 0;
    end
    e.st = m_st[i]; e.n = m_n[i]; e.r = rmode(m_p[i]); e.tx = m_tx[i]; e.ty = m_ty[i];
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  always @(posedge Clk) begin
    model_step(0, 8);
    model_step(1, 60);
  end

  always @(negedge Clk) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      popped++;
      chk("i0_state", int'(state0), e0.st);
      chk("i0_len",   int'(len0),   e0.n);
      chk("i0_rmode", int'(r0),     e0.r);
      chk("i0_tailx", int'(tx0),    e0.tx);
      chk("i0_taily", int'(ty0),    e0.ty);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      chk("i1_state", int'(state1), e1.st);
      chk("i1_len",   int'(len1),   e1.n);
      chk("i1_rmode", int'(r1),     e1.r);
      chk("i1_tailx", int'(tx1),    e1.tx);
      chk("i1_taily", int'(ty1),    e1.ty);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx, last_r, k, mx, my, mlen, badx, hold_bad, ret_r;
    bit seen;
    rst_in = 1'b1; ng_in = 1'b0; fire_in = 1'b0; catch_in = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_state", int'(state0), 0);
    chk("rst_rmode", int'(r0), 5);
    chk("rst_len",   int'(len0), 0);
    chk("rst_tailx", int'(tx0), 320);
    chk("rst_taily", int'(ty0), 40);
    rst_in = 1'b0;

    // free swing
    idx = 0; last_r = 5; k = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge Clk);
      if (int'(r0) != last_r) begin
        if (idx < 10) chk("swing_seq", int'(r0), SWING_EXP[idx]);
        if (idx > 0) chk("swing_period", c - k, 4);
        idx++; last_r = int'(r0); k = c;
      end
    end
    chk("swing_steps", idx, 12);

    // straight throw at R_mode 5, fire kept high
    rst_in = 1'b1; @(negedge Clk); rst_in = 1'b0; fire_in = 1'b1;
    my = 0; mlen = 0; badx = 0; ret_r = -1; seen = 0;
    for (k = 0; k < 400; k++) begin
      @(negedge Clk);
      if (state0 != 3'd0) seen = 1;
      if (int'(ty0) > my) my = int'(ty0);
      if (int'(len0) > mlen) mlen = int'(len0);
      if (tx0 != 10'd320) badx++;
      if (seen && state0 == 3'd0 && ret_r < 0) ret_r = int'(r0);
      if (seen && state0 == 3'd0 && state1 == 3'd0) break;
    end
    chk("throw_done", (seen && state0 == 3'd0 && state1 == 3'd0) ? 1 : 0, 1);
    chk("throw_max_y", my, 88);
    chk("throw_max_len", mlen, 8);
    chk("throw_x_fixed", badx, 0);
    chk("throw_ret_rmode", ret_r, 5);
    hold_bad = 0;
    repeat (30) begin
      @(negedge Clk);
      if (state0 != 3'd0 || state1 != 3'd0) hold_bad++;
    end
    chk("fire_hold_no_relaunch", hold_bad, 0);
    fire_in = 1'b0;

    // catch during extend at n=3
    @(negedge Clk); fire_in = 1'b1; @(negedge Clk); fire_in = 1'b0;
    for (k = 0; k < 100 && !(state0 == 3'd1 && len0 == 10'd3); k++) @(negedge Clk);
    chk("catch_reach_n3", (state0 == 3'd1 && len0 == 10'd3) ? 1 : 0, 1);
    catch_in = 1'b1; @(negedge Clk); catch_in = 1'b0;
    chk("catch_state", int'(state0), 3);
    chk("catch_len", int'(len0), 3);
    for (k = 0; k < 100 && state0 != 3'd0; k++) @(negedge Clk);
    chk("catch_to_swing", k, 19);

    // screen edge at R_mode 0, with a fire pulse during extend
    for (k = 0; k < 300 && !(r1 == 4'd0 && state0 == 3'd0 && state1 == 3'd0); k++) @(negedge Clk);
    chk("edge_rmode0", (r1 == 4'd0 && state1 == 3'd0) ? 1 : 0, 1);
    fire_in = 1'b1; @(negedge Clk); fire_in = 1'b0;
    chk("edge_launch", int'(state1), 1);
    chk("edge_rmode_frozen", int'(r1), 0);
    mx = 0; mlen = 0;
    for (k = 0; k < 400; k++) begin
      @(negedge Clk);
      fire_in = (k == 10 || k == 11) ? 1'b1 : 1'b0;
      if (int'(tx1) > mx) mx = int'(tx1);
      if (int'(len1) > mlen) mlen = int'(len1);
      if (state0 == 3'd0 && state1 == 3'd0 && k > 20) break;
    end
    fire_in = 1'b0;
    chk("edge_done", (state0 == 3'd0 && state1 == 3'd0) ? 1 : 0, 1);
    chk("edge_max_x", mx, 638);
    chk("edge_max_len", mlen, 53);

    // reset in the middle of a loaded retract
    @(negedge Clk); fire_in = 1'b1; @(negedge Clk); fire_in = 1'b0;
    for (k = 0; k < 100 && !(state0 == 3'd1 && len0 == 10'd6); k++) @(negedge Clk);
    chk("mid_reach_n6", (state0 == 3'd1 && len0 == 10'd6) ? 1 : 0, 1);
    catch_in = 1'b1; @(negedge Clk); catch_in = 1'b0;
    for (k = 0; k < 100 && !(state0 == 3'd3 && len0 == 10'd5); k++) @(negedge Clk);
    chk("mid_reach_n5", (state0 == 3'd3 && len0 == 10'd5) ? 1 : 0, 1);
    rst_in = 1'b1; @(negedge Clk); rst_in = 1'b0;
    chk("mid_rst_state", int'(state0), 0);
    chk("mid_rst_rmode", int'(r0), 5);
    chk("mid_rst_len", int'(len0), 0);
    @(negedge Clk);
    chk("mid_rst_tailx", int'(tx0), 320);
    chk("mid_rst_taily", int'(ty0), 40);

    // randomized play
    for (int c = 0; c < 4000; c++) begin
      @(negedge Clk);
      if ($urandom_range(0, 99) < 8) fire_in = ~fire_in;
      catch_in = ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
      ng_in    = ($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0;
      rst_in   = ($urandom_range(0, 999) < 2) ? 1'b1 : 1'b0;
    end
    rst_in = 1'b0; ng_in = 1'b0; fire_in = 1'b0; catch_in = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    chk("sb_drain0", q0.size(), 0);
    chk("sb_drain1", q1.size(), 0);
    chk("sb_compared", (popped > 4000) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
